// File: rtl/layer_readout_ctrl_if.sv
// Bundles the sequencer start, accumulator read/clear bus and output element stream
// of layer_readout_ctrl; master is the controller, slave is its environment.
interface layer_readout_ctrl_if #(
  parameter int ACC_W  = 32,
  parameter int DATA_W = 16
);
  logic              start_layering;
  logic [2:0]        acc_sel;
  logic              layer_ctrl_busy;
  logic              acc_rd_en;
  logic [1:0]        acc_rd_mac;
  logic [2:0]        acc_rd_sel;
  logic [ACC_W-1:0]  acc_rd_data;
  logic              acc_clr;
  logic [DATA_W-1:0] y_data;
  logic [4:0]        y_idx;
  logic              y_valid;
  logic              y_ready;
  logic              y_last;

  modport master (
    input  start_layering, acc_sel, acc_rd_data, y_ready,
    output layer_ctrl_busy, acc_rd_en, acc_rd_mac, acc_rd_sel, acc_clr,
           y_data, y_idx, y_valid, y_last
  );

  modport slave (
    output start_layering, acc_sel, acc_rd_data, y_ready,
    input  layer_ctrl_busy, acc_rd_en, acc_rd_mac, acc_rd_sel, acc_clr,
           y_data, y_idx, y_valid, y_last
  );
endinterface

// File: rtl/layer_readout_ctrl.sv
// Reads one accumulator bank from the four MACs, shifts/saturates each value into a
// streamed output element, then clears the bank. Optional macro: LAYER_RELU_EN.
module layer_readout_ctrl #(
  parameter int ACC_W  = 32,
  parameter int DATA_W = 16,
  parameter int SHIFT  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  layer_readout_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, CLEAR} state_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [2:0]        sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              rd_en_q, rd_en_d;
  logic              clr_q, clr_d;
  logic [DATA_W-1:0] y_data_q, y_data_d;
  logic [4:0]        y_idx_q, y_idx_d;
  logic              y_valid_q, y_valid_d;
  logic              y_last_q, y_last_d;

  // Arithmetic shift floors toward -inf; the result is then clamped to the DATA_W range.
  function automatic logic [DATA_W-1:0] format_acc(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shifted;
    shifted = acc >>> SHIFT;
`ifdef LAYER_RELU_EN
    if (shifted < 0) shifted = '0;
`endif
    if (shifted > SAT_MAX)      format_acc = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) format_acc = SAT_MIN[DATA_W-1:0];
    else                        format_acc = shifted[DATA_W-1:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    rd_en_d   = 1'b0;
    clr_d     = 1'b0;
    y_data_d  = y_data_q;
    y_idx_d   = y_idx_q;
    y_valid_d = y_valid_q;
    y_last_d  = y_last_q;
    unique case (state_q)
      IDLE: begin
        // busy_q still covers the first IDLE cycle after CLEAR, so a start there is ignored
        if (bus.start_layering && !busy_q) begin
          sel_d   = bus.acc_sel;
          cnt_d   = 2'd0;
          rd_en_d = 1'b1;
          state_d = READ;
        end
      end
      READ: state_d = WAIT;
      WAIT: begin
        y_data_d  = format_acc($signed(bus.acc_rd_data));
        y_idx_d   = {sel_q, cnt_q};
        y_valid_d = 1'b1;
        y_last_d  = (cnt_q == 2'd3);
        state_d   = SEND;
      end
      SEND: begin
        if (bus.y_ready) begin
          y_valid_d = 1'b0;
          y_last_d  = 1'b0;
          if (cnt_q == 2'd3) begin
            clr_d   = 1'b1;
            state_d = CLEAR;
          end else begin
            cnt_d   = cnt_q + 2'd1;
            rd_en_d = 1'b1;
            state_d = READ;
          end
        end
      end
      CLEAR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_q != IDLE) || (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      clr_q     <= 1'b0;
      y_data_q  <= '0;
      y_idx_q   <= '0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      rd_en_q   <= rd_en_d;
      clr_q     <= clr_d;
      y_data_q  <= y_data_d;
      y_idx_q   <= y_idx_d;
      y_valid_q <= y_valid_d;
      y_last_q  <= y_last_d;
    end
  end

  assign bus.layer_ctrl_busy = busy_q;
  assign bus.acc_rd_en       = rd_en_q;
  assign bus.acc_rd_mac      = cnt_q;
  assign bus.acc_rd_sel      = sel_q;
  assign bus.acc_clr         = clr_q;
  assign bus.y_data          = y_data_q;
  assign bus.y_idx           = y_idx_q;
  assign bus.y_valid         = y_valid_q;
  assign bus.y_last          = y_last_q;

endmodule

// File: tb/tb_layer_readout_ctrl.sv
// Directed, table-driven bench for layer_readout_ctrl; expected element values follow
// the LAYER_RELU_EN setting of the build.
module tb_layer_readout_ctrl;

  localparam int ACC_W  = 32;
  localparam int DATA_W = 16;
  localparam int SHIFT  = 8;
`ifdef LAYER_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef struct {
    logic [2:0]        sel;
    logic [3:0][31:0]  acc;
    logic [3:0][15:0]  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  layer_readout_ctrl_if #(.ACC_W(ACC_W), .DATA_W(DATA_W)) bus ();

  layer_readout_ctrl #(.ACC_W(ACC_W), .DATA_W(DATA_W), .SHIFT(SHIFT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:31];
  logic [15:0] hs_data [$];
  logic [4:0]  hs_idx  [$];
  logic        hs_last [$];
  logic [2:0]  clr_sel [$];
  int busy_cycles, rd_cnt, both_hi;

  // Accumulator memory model with one-cycle read latency, plus a bus monitor
  always @(posedge clk) begin
    bus.acc_rd_data <= bus.acc_rd_en ? mem[{bus.acc_rd_sel, bus.acc_rd_mac}] : 32'hDEAD_BEEF;
    if (rst_n) begin
      if (bus.y_valid && bus.y_ready) begin
        hs_data.push_back(bus.y_data);
        hs_idx.push_back(bus.y_idx);
        hs_last.push_back(bus.y_last);
      end
      if (bus.acc_clr) clr_sel.push_back(bus.acc_rd_sel);
      if (bus.acc_rd_en) rd_cnt++;
      if (bus.layer_ctrl_busy) busy_cycles++;
      if (bus.acc_rd_en && bus.acc_clr) both_hi++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit stall, input bit repulse);
    int n;
    bit stalled;
    logic [15:0] hold_data;
    logic [4:0]  hold_idx;
    int rd_before;
    hs_data.delete(); hs_idx.delete(); hs_last.delete(); clr_sel.delete();
    busy_cycles = 0; rd_cnt = 0; both_hi = 0;
    for (int m = 0; m < 4; m++) mem[{v.sel, 2'(m)}] = v.acc[m];
    bus.y_ready = 1'b1;
    @(negedge clk);
    bus.start_layering = 1'b1;
    bus.acc_sel = v.sel;
    @(negedge clk);
    bus.start_layering = 1'b0;
    bus.acc_sel = 3'd5;
    n = 0;
    stalled = 1'b0;
    while (bus.layer_ctrl_busy && n < 300) begin
      bus.start_layering = (repulse && n == 4);
      if (stall && !stalled && bus.y_valid && bus.y_idx[1:0] == 2'd1) begin
        stalled = 1'b1;
        bus.y_ready = 1'b0;
        hold_data = bus.y_data;
        hold_idx = bus.y_idx;
        rd_before = rd_cnt;
        repeat (5) begin
          @(negedge clk);
          n++;
          checkOutput("stall_valid", 32'(bus.y_valid), 32'd1);
          checkOutput("stall_data", 32'(bus.y_data), 32'(hold_data));
          checkOutput("stall_idx", 32'(bus.y_idx), 32'(hold_idx));
        end
        checkOutput("stall_no_read", rd_cnt, rd_before);
        bus.y_ready = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    bus.start_layering = 1'b0;
    checkOutput("done_in_time", 32'(n < 300), 32'd1);
    if (stall) checkOutput("stall_seen", 32'(stalled), 32'd1);
    checkOutput("elem_count", hs_data.size(), 32'd4);
    if (hs_data.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("y_data[%0d]", i), 32'(hs_data[i]), 32'(v.exp[i]));
        checkOutput($sformatf("y_idx[%0d]", i), 32'(hs_idx[i]), 32'({v.sel, 2'(i)}));
        checkOutput($sformatf("y_last[%0d]", i), 32'(hs_last[i]), 32'(i == 3));
      end
    end
    checkOutput("clr_count", clr_sel.size(), 32'd1);
    if (clr_sel.size() == 1) checkOutput("clr_sel", 32'(clr_sel[0]), 32'(v.sel));
    checkOutput("rd_count", rd_cnt, 32'd4);
    checkOutput("rd_clr_overlap", both_hi, 32'd0);
    checkOutput("busy_cycles", busy_cycles, stall ? 32'd19 : 32'd14);
  endtask

  vec_t vecs [4];

  initial begin
    int n;
    vecs[0].sel = 3'd1;
    vecs[0].acc = {32'h0000_7F00, 32'h0000_0000, 32'h0000_0100, 32'h0000_1234};
    vecs[0].exp = {16'h007F, 16'h0000, 16'h0001, 16'h0012};
    vecs[1].sel = 3'd6;
    vecs[1].acc = {32'h0000_00FF, 32'hFFFF_0000, 32'h8000_0000, 32'h0100_0000};
    vecs[1].exp = {16'h0000, RELU ? 16'h0000 : 16'hFF00, RELU ? 16'h0000 : 16'h8000, 16'h7FFF};
    vecs[2].sel = 3'd0;
    vecs[2].acc = {32'h007F_FFFF, 32'hFF80_0000, 32'h7FFF_FF00, 32'hFFFF_FF00};
    vecs[2].exp = {16'h7FFF, RELU ? 16'h0000 : 16'h8000, 16'h7FFF, RELU ? 16'h0000 : 16'hFFFF};
    vecs[3].sel = 3'd7;
    vecs[3].acc = {32'hFF7F_FF00, 32'h0080_0000, 32'hFFFF_FE80, 32'h0000_0180};
    vecs[3].exp = {RELU ? 16'h0000 : 16'h8000, 16'h7FFF, RELU ? 16'h0000 : 16'hFFFE, 16'h0001};

    rst_n = 1'b0;
    bus.start_layering = 1'b0;
    bus.acc_sel = 3'd0;
    bus.y_ready = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
      32'({bus.layer_ctrl_busy, bus.acc_rd_en, bus.acc_rd_mac, bus.acc_rd_sel, bus.acc_clr,
           bus.y_data, bus.y_idx, bus.y_valid, bus.y_last}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i], 1'b0, 1'b0);

    $display("[TB] stall on element 2");
    applyStimulus(vecs[0], 1'b1, 1'b0);

    $display("[TB] ignored restart during readout of bank 2");
    vecs[2].sel = 3'd2;
    for (int m = 0; m < 4; m++) mem[{3'd5, 2'(m)}] = 32'h0000_5500;
    applyStimulus(vecs[2], 1'b0, 1'b1);

    $display("[TB] reset during first element");
    clr_sel.delete();
    for (int m = 0; m < 4; m++) mem[{3'd3, 2'(m)}] = 32'h0000_0A00;
    bus.y_ready = 1'b0;
    @(negedge clk);
    bus.start_layering = 1'b1;
    bus.acc_sel = 3'd3;
    @(negedge clk);
    bus.start_layering = 1'b0;
    n = 0;
    while (!bus.y_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_valid_seen", 32'(bus.y_valid), 32'd1);
    checkOutput("rst_elem_idx", 32'(bus.y_idx), 32'({3'd3, 2'd0}));
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_outputs",
      32'({bus.layer_ctrl_busy, bus.acc_rd_en, bus.acc_rd_mac, bus.acc_rd_sel, bus.acc_clr,
           bus.y_data, bus.y_idx, bus.y_valid, bus.y_last}), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_no_clr", clr_sel.size(), 32'd0);
    checkOutput("rst_idle", 32'(bus.layer_ctrl_busy), 32'd0);
    vecs[3].sel = 3'd3;
    vecs[3].acc = {32'h0000_0400, 32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    vecs[3].exp = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    applyStimulus(vecs[3], 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
